ws2812_frame_buffer: RTL and testbench

- Upstream stage of the RZ encoder: holds one frame of LED_NUM 24-bit pixels written by a host-side port.
- On request, streams the frame pixel-by-pixel to the RZ encoder using its data_ready / data_end / RGB / tx_done handshake.
- Applies a global brightness scale and channel reorder per pixel.
- After the last pixel, holds the inter-frame latch gap so the strip latches.

---
 rtl/ws2812_pkg.sv | 35 +++
 rtl/ws2812_pixel_ram.sv | 33 +++
 rtl/ws2812_frame_buffer.sv | 132 +++++++++++++
 tb/tb_ws2812_frame_buffer.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame buffer: FSM encoding,
// pixel width, channel-order selectors and derived timing helpers.
package ws2812_pkg;

  localparam int PIX_W = 24;

  localparam bit ORDER_RGB = 1'b0;
  localparam bit ORDER_GRB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_SCALE     = 3'd2,
    ST_SEND      = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_LATCH     = 3'd5
  } state_e;

  function automatic int latch_cyc(input int clk_freq_hz, input int reset_us);
    return (clk_freq_hz / 1000000) * reset_us;
  endfunction

  // Address bits needed to index exactly LED_NUM RAM entries.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (c * (b + 1)) >> 8: b = 255 passes c through, b = 0 gives 0.
  function automatic logic [7:0] scale8(input logic [7:0] c, input logic [8:0] m);
    logic [15:0] p;
    p = {8'b0, c} * {7'b0, m};
    return p[15:8];
  endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// One frame of pixels: single write port, single synchronous read-first port.
// Out-of-range writes are dropped so they cannot alias onto a real pixel.
module ws2812_pixel_ram
  import ws2812_pkg::*;
#(
  parameter int LED_NUM = 64,
  parameter int ADDR_W  = 6
) (
  input  logic                       clk,
  input  logic                       wr_en_i,
  input  logic [ADDR_W-1:0]          wr_addr_i,
  input  logic [PIX_W-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  input  logic [idx_w(LED_NUM)-1:0]  rd_addr_i,
  output logic [PIX_W-1:0]           rd_data_o
);

  localparam int IDX_W = idx_w(LED_NUM);

  logic [PIX_W-1:0] mem_q [LED_NUM];
  logic [PIX_W-1:0] rd_data_q;
  logic             wr_ok;

  assign wr_ok = wr_en_i && ({1'b0, wr_addr_i} < (ADDR_W+1)'(LED_NUM));

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_addr_i[IDX_W-1:0]] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ws2812_frame_buffer.sv
// Frame buffer feeding the WS2812 RZ encoder: stores one frame, streams it
// pixel by pixel with brightness scaling and channel reorder, then holds the latch gap.
module ws2812_frame_buffer
  import ws2812_pkg::*;
#(
  parameter int LED_NUM     = 64,
  parameter int ADDR_W      = 6,
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int RESET_US    = 300,
  parameter bit GRB_ORDER   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic [7:0]        brightness,
  input  logic              frame_start,
  output logic              busy,
  output logic              frame_done,
  output logic              data_ready,
  output logic              data_end,
  output logic [PIX_W-1:0]  RGB,
  input  logic              tx_done,
  output state_e            state_dbg
);

  localparam int LATCH_CYC = latch_cyc(CLK_FREQ_HZ, RESET_US);
  localparam int LAT_W     = $clog2(LATCH_CYC + 1);
  localparam int IDX_W     = idx_w(LED_NUM);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pix_cnt_q;
  logic               pending_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic [7:0]         bright_q;
  logic [PIX_W-1:0]   rgb_q;
  logic [PIX_W-1:0]   ram_rdata;
  logic [PIX_W-1:0]   rgb_scaled;
  logic [8:0]         scale_mul;
  logic [7:0]         ch_r, ch_g, ch_b;
  logic               start_ok, last_pix, last_lat;

  assign start_ok = frame_start || pending_q;
  assign last_pix = (pix_cnt_q == ADDR_W'(LED_NUM - 1));
  assign last_lat = (lat_cnt_q == LAT_W'(LATCH_CYC - 1));

  ws2812_pixel_ram #(.LED_NUM(LED_NUM), .ADDR_W(ADDR_W)) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (state_q == ST_FETCH),
    .rd_addr_i (pix_cnt_q[IDX_W-1:0]),
    .rd_data_o (ram_rdata)
  );

  assign scale_mul  = {1'b0, bright_q} + 9'd1;
  assign ch_r       = scale8(ram_rdata[23:16], scale_mul);
  assign ch_g       = scale8(ram_rdata[15:8], scale_mul);
  assign ch_b       = scale8(ram_rdata[7:0], scale_mul);
  assign rgb_scaled = (GRB_ORDER == ORDER_GRB) ? {ch_g, ch_r, ch_b} : {ch_r, ch_g, ch_b};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_cnt_q <= '0;
      pending_q <= 1'b0;
      lat_cnt_q <= '0;
      bright_q  <= '0;
      rgb_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start_ok) begin
          bright_q  <= brightness;
          pix_cnt_q <= '0;
          pending_q <= 1'b0;
          lat_cnt_q <= '0;
        end
        ST_SCALE:     rgb_q <= rgb_scaled;
        ST_WAIT_DONE: if (tx_done && !last_pix) pix_cnt_q <= pix_cnt_q + 1'b1;
        ST_LATCH:     lat_cnt_q <= lat_cnt_q + 1'b1;
        default: ;
      endcase
      // A request while a frame is in flight is remembered once; repeats merge.
      if (frame_start && state_q != ST_IDLE) pending_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start_ok) state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_SCALE;
      ST_SCALE:     state_d = ST_SEND;
      ST_SEND:      state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (tx_done) state_d = last_pix ? ST_LATCH : ST_FETCH;
      ST_LATCH:     if (last_lat) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Encoder handshake: data_ready pulses one cycle with RGB valid; the encoder
  // answers with a one-cycle tx_done when those 24 bits are on the wire.
  always_comb begin
    busy       = 1'b0;
    frame_done = 1'b0;
    data_ready = 1'b0;
    data_end   = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_SEND: begin
        busy       = 1'b1;
        data_ready = 1'b1;
      end
      ST_LATCH: begin
        data_end   = 1'b1;
        frame_done = last_lat;
        busy       = !last_lat;
      end
      default: busy = 1'b1;
    endcase
  end

  assign RGB       = rgb_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ws2812_frame_buffer.sv
// Directed bench for ws2812_frame_buffer with LED_NUM=4 and a 20-cycle latch gap.
module tb_ws2812_frame_buffer;
  import ws2812_pkg::*;

  localparam int LED_NUM = 4;
  localparam int ADDR_W  = 3;

  typedef logic [23:0] px_arr_t [4];

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [23:0]       wr_data = '0;
  logic [7:0]        brightness = 8'd255;
  logic              frame_start = 1'b0;
  logic              tx_done = 1'b0;
  logic              busy, frame_done, data_ready, data_end;
  logic [23:0]       RGB;
  state_e            state_dbg;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  px_arr_t exp_full, exp_half;

  ws2812_frame_buffer #(
    .LED_NUM(LED_NUM), .ADDR_W(ADDR_W), .CLK_FREQ_HZ(1000000), .RESET_US(20), .GRB_ORDER(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .brightness(brightness), .frame_start(frame_start), .busy(busy), .frame_done(frame_done),
    .data_ready(data_ready), .data_end(data_end), .RGB(RGB), .tx_done(tx_done),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1);
  end

  // One step: just past the rising edge; pulses asserted in the previous step drop.
  task automatic tick;
    @(posedge clk);
    #1;
    tx_done = 1'b0;
    frame_start = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic write_px(input logic [ADDR_W-1:0] a, input logic [23:0] d);
    tick;
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  // Plays the encoder for n pixels: tx_done 30 cycles after each data_ready.
  task automatic serve_pixels(input int n, input int trig0, input bit extra_starts,
                              input bit late_wr, output px_arr_t got, output int lat[4],
                              output bit single[4], output int timeouts);
    int trig;
    bit seen;
    trig = trig0;
    timeouts = 0;
    for (int i = 0; i < 4; i++) begin
      got[i] = '0;
      lat[i] = -1;
      single[i] = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      seen = 1'b0;
      for (int t = 0; t < 60; t++) begin
        tick;
        if (t == 0 && late_wr && i == 3) begin
          wr_en = 1'b1;
          wr_addr = 3'd3;
          wr_data = 24'hABCDEF;
        end
        if (data_ready) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        timeouts++;
        break;
      end
      got[i] = RGB;
      lat[i] = cyc - trig;
      if (extra_starts && (i == 1 || i == 2)) frame_start = 1'b1;
      tick;
      single[i] = (data_ready === 1'b0);
      repeat (29) tick;
      tx_done = 1'b1;
      trig = cyc;
    end
  endtask

  // Observes the latch gap after the last tx_done, stopping on frame_done.
  task automatic finish_latch(input bit spurious, output int de_cnt, output int fd_pos,
                              output bit busy_at_fd, output int dr_cnt, output int fd_step);
    de_cnt = 0;
    fd_pos = 0;
    busy_at_fd = 1'b1;
    dr_cnt = 0;
    fd_step = 0;
    for (int k = 1; k <= 60; k++) begin
      tick;
      if (spurious && k == 5) tx_done = 1'b1;
      if (data_end === 1'b1) de_cnt++;
      if (data_ready === 1'b1) dr_cnt++;
      if (frame_done === 1'b1) begin
        fd_pos = k;
        busy_at_fd = busy;
        fd_step = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) tick;
    checks++;
    if ({busy, frame_done, data_ready, data_end} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=0000", {busy, frame_done, data_ready, data_end});
    end
    checks++;
    if (RGB !== 24'h0) begin
      errors++;
      $display("FAIL reset_rgb got=%h exp=000000", RGB);
    end
    checks++;
    if (state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_frame_order;
    px_arr_t got;
    int lat[4];
    bit single[4];
    int to, t0;
    write_px(3'd0, 24'hFF0000);
    write_px(3'd1, 24'h00FF00);
    write_px(3'd2, 24'h0000FF);
    write_px(3'd3, 24'h123456);
    brightness = 8'd255;
    tick;
    frame_start = 1'b1;
    t0 = cyc;
    serve_pixels(4, t0, 1'b0, 1'b0, got, lat, single, to);
    checks++;
    if (to !== 0) begin
      errors++;
      $display("FAIL order_timeout got=%0d exp=0", to);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp_full[i]) begin
        errors++;
        $display("FAIL order_rgb[%0d] got=%h exp=%h", i, got[i], exp_full[i]);
      end
      checks++;
      if (lat[i] !== 3) begin
        errors++;
        $display("FAIL order_latency[%0d] got=%0d exp=3", i, lat[i]);
      end
      checks++;
      if (single[i] !== 1'b1) begin
        errors++;
        $display("FAIL order_ready_width[%0d] got=%b exp=1", i, single[i]);
      end
    end
  endtask

  task automatic test_latch;
    int de, fdp, dr, fds;
    bit bfd;
    finish_latch(1'b0, de, fdp, bfd, dr, fds);
    checks++;
    if (de !== 20) begin
      errors++;
      $display("FAIL latch_data_end_len got=%0d exp=20", de);
    end
    checks++;
    if (fdp !== 20) begin
      errors++;
      $display("FAIL latch_frame_done_pos got=%0d exp=20", fdp);
    end
    checks++;
    if (bfd !== 1'b0) begin
      errors++;
      $display("FAIL latch_busy_at_done got=%b exp=0", bfd);
    end
    checks++;
    if (dr !== 0) begin
      errors++;
      $display("FAIL latch_data_ready got=%0d exp=0", dr);
    end
    tick;
    checks++;
    if ({frame_done, data_end, busy} !== 3'b000 || state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL latch_after got=fd%b de%b busy%b st%0d exp=0 0 0 IDLE",
               frame_done, data_end, busy, state_dbg);
    end
  endtask

  task automatic test_scale;
    px_arr_t got;
    int lat[4];
    bit single[4];
    int to, t0, de, fdp, dr, fds;
    bit bfd;
    write_px(3'd0, 24'hFF8040);
    brightness = 8'd127;
    tick;
    frame_start = 1'b1;
    t0 = cyc;
    tick;
    brightness = 8'd0;
    serve_pixels(4, t0, 1'b0, 1'b0, got, lat, single, to);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp_half[i]) begin
        errors++;
        $display("FAIL scale127_rgb[%0d] got=%h exp=%h", i, got[i], exp_half[i]);
      end
    end
    finish_latch(1'b0, de, fdp, bfd, dr, fds);
    tick;
    frame_start = 1'b1;
    t0 = cyc;
    serve_pixels(4, t0, 1'b0, 1'b0, got, lat, single, to);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== 24'h000000 || lat[i] !== 3) begin
        errors++;
        $display("FAIL scale0_rgb[%0d] got=%h lat=%0d exp=000000 lat=3", i, got[i], lat[i]);
      end
    end
    finish_latch(1'b0, de, fdp, bfd, dr, fds);
    write_px(3'd0, 24'hFF0000);
    brightness = 8'd255;
  endtask

  task automatic test_pending;
    px_arr_t got;
    int lat[4];
    bit single[4];
    int to, t0, de, fdp, dr, fds, act;
    bit bfd;
    tick;
    frame_start = 1'b1;
    t0 = cyc;
    serve_pixels(4, t0, 1'b1, 1'b0, got, lat, single, to);
    finish_latch(1'b1, de, fdp, bfd, dr, fds);
    checks++;
    if (de !== 20 || fdp !== 20) begin
      errors++;
      $display("FAIL pending_latch_spurious got=de%0d fd%0d exp=20 20", de, fdp);
    end
    serve_pixels(4, fds + 1, 1'b0, 1'b0, got, lat, single, to);
    checks++;
    if (to !== 0 || lat[0] !== 3) begin
      errors++;
      $display("FAIL pending_restart got=timeouts%0d lat%0d exp=0 3", to, lat[0]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp_full[i]) begin
        errors++;
        $display("FAIL pending_rgb[%0d] got=%h exp=%h", i, got[i], exp_full[i]);
      end
    end
    finish_latch(1'b0, de, fdp, bfd, dr, fds);
    tick;
    tx_done = 1'b1;
    act = 0;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (busy !== 1'b0 || data_ready !== 1'b0 || state_dbg !== ST_IDLE) act++;
    end
    checks++;
    if (act !== 0) begin
      errors++;
      $display("FAIL pending_merge_idle_tx got=%0d active cycles exp=0", act);
    end
  endtask

  task automatic test_reset_midframe;
    px_arr_t got;
    int lat[4];
    bit single[4];
    int to, t0, de, fdp, dr, fds, act;
    bit bfd, seen;
    tick;
    frame_start = 1'b1;
    t0 = cyc;
    serve_pixels(2, t0, 1'b0, 1'b0, got, lat, single, to);
    seen = 1'b0;
    for (int t = 0; t < 60; t++) begin
      tick;
      if (data_ready) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstmid_reach_px2 got=timeout exp=data_ready");
    end
    repeat (5) tick;
    rst_n = 1'b0;
    tick;
    checks++;
    if ({busy, frame_done, data_ready, data_end} !== 4'b0000 || RGB !== 24'h0 ||
        state_dbg !== ST_IDLE) begin
      errors++;
      $display("FAIL rstmid_outputs got=%b rgb=%h st=%0d exp=0000 000000 IDLE",
               {busy, frame_done, data_ready, data_end}, RGB, state_dbg);
    end
    rst_n = 1'b1;
    act = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (frame_done !== 1'b0 || data_ready !== 1'b0 || busy !== 1'b0) act++;
    end
    checks++;
    if (act !== 0) begin
      errors++;
      $display("FAIL rstmid_quiet got=%0d active cycles exp=0", act);
    end
    tick;
    frame_start = 1'b1;
    t0 = cyc;
    serve_pixels(4, t0, 1'b0, 1'b0, got, lat, single, to);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== exp_full[i]) begin
        errors++;
        $display("FAIL rstmid_ram_rgb[%0d] got=%h exp=%h", i, got[i], exp_full[i]);
      end
    end
    finish_latch(1'b0, de, fdp, bfd, dr, fds);
  endtask

  task automatic test_read_first;
    px_arr_t got;
    int lat[4];
    bit single[4];
    int to, t0, de, fdp, dr, fds;
    bit bfd;
    write_px(3'd4, 24'h555555);
    tick;
    frame_start = 1'b1;
    t0 = cyc;
    serve_pixels(4, t0, 1'b0, 1'b1, got, lat, single, to);
    checks++;
    if (got[3] !== 24'h341256) begin
      errors++;
      $display("FAIL rdfirst_old got=%h exp=341256", got[3]);
    end
    finish_latch(1'b0, de, fdp, bfd, dr, fds);
    tick;
    frame_start = 1'b1;
    t0 = cyc;
    serve_pixels(4, t0, 1'b0, 1'b0, got, lat, single, to);
    checks++;
    if (got[3] !== 24'hCDABEF) begin
      errors++;
      $display("FAIL rdfirst_new got=%h exp=cdabef", got[3]);
    end
    checks++;
    if (got[0] !== 24'h00FF00) begin
      errors++;
      $display("FAIL oob_write_px0 got=%h exp=00ff00", got[0]);
    end
    finish_latch(1'b0, de, fdp, bfd, dr, fds);
  endtask

  initial begin
    exp_full = '{24'h00FF00, 24'hFF0000, 24'h0000FF, 24'h341256};
    exp_half = '{24'h407F20, 24'h7F0000, 24'h00007F, 24'h1A092B};
    test_reset;
    test_frame_order;
    test_latch;
    test_scale;
    test_pending;
    test_reset_midframe;
    test_read_first;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
